// File: rtl/psum_bank_ctrl.sv
// Partial-sum bank controller: arbitrates one write/accumulate requester and one read requester
// onto a single-port SRAM bank, performing accumulates as read + lane-wise add + write-back.
module psum_bank_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 32,
    parameter int addr_bw = 11
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   wr_req,
    input  logic                   wr_acc,
    input  logic [addr_bw-1:0]     wr_addr,
    input  logic [psum_bw*col-1:0] wr_data,
    output logic                   wr_ready,
    input  logic                   rd_req,
    input  logic [addr_bw-1:0]     rd_addr,
    output logic                   rd_ready,
    output logic                   rd_valid,
    output logic [psum_bw*col-1:0] rd_data,
    output logic                   busy,
    output logic                   sram_CEN,
    output logic                   sram_WEN,
    output logic [addr_bw-1:0]     sram_A,
    output logic [psum_bw*col-1:0] sram_D,
    input  logic [psum_bw*col-1:0] sram_Q
);

    localparam int DW = psum_bw * col;

    typedef enum logic {
        ISSUE  = 1'b0,
        ACC_WB = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_ptr;          // 0 = write requester wins the next contended cycle
    logic               r_rd_valid;
    logic [addr_bw-1:0] r_acc_addr;
    logic [DW-1:0]      r_acc_data;
    logic [DW-1:0]      w_sum;
    logic               w_grant_wr;
    logic               w_grant_rd;
    logic               w_contend;

    // Lane-wise modulo add; each lane slice truncates its own carry.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < col; i++) begin
            w_sum[i*psum_bw +: psum_bw] = sram_Q[i*psum_bw +: psum_bw] + r_acc_data[i*psum_bw +: psum_bw];
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        w_next     = r_state;
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        w_contend  = 1'b0;
        busy       = 1'b0;
        sram_CEN   = 1'b1;
        sram_WEN   = 1'b1;
        sram_A     = '0;
        sram_D     = '0;
        if (!reset) begin
            case (r_state)
                ISSUE: begin
                    w_contend  = wr_req & rd_req;
                    w_grant_wr = wr_req & (~rd_req | ~r_ptr);
                    w_grant_rd = rd_req & (~wr_req | r_ptr);
                    if (w_grant_wr) begin
                        sram_CEN = 1'b0;
                        sram_A   = wr_addr;
                        if (wr_acc) begin
                            w_next = ACC_WB;
                        end else begin
                            sram_WEN = 1'b0;
                            sram_D   = wr_data;
                        end
                    end else if (w_grant_rd) begin
                        sram_CEN = 1'b0;
                        sram_A   = rd_addr;
                    end
                end
                ACC_WB: begin
                    busy     = 1'b1;
                    sram_CEN = 1'b0;
                    sram_WEN = 1'b0;
                    sram_A   = r_acc_addr;
                    sram_D   = w_sum;
                    w_next   = ISSUE;
                end
                default: w_next = ISSUE;
            endcase
        end
    end

    assign wr_ready = w_grant_wr;
    assign rd_ready = w_grant_rd;
    assign rd_valid = r_rd_valid & ~reset;
    assign rd_data  = sram_Q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= ISSUE;
            r_ptr      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= w_grant_rd;
            if (w_contend) begin
                r_ptr <= ~r_ptr;
            end
        end
    end

    // NOTE: the accumulate operand registers carry no reset; they are only consumed after a load.
    always_ff @(posedge CLK) begin
        if (w_grant_wr && wr_acc) begin
            r_acc_addr <= wr_addr;
            r_acc_data <= wr_data;
        end
    end

endmodule

// File: tb/tb_psum_bank_ctrl.sv
// Directed bench for psum_bank_ctrl with a behavioural single-port SRAM attached to the bank port.
module tb_psum_bank_ctrl;

    localparam int COL = 8;
    localparam int BW  = 32;
    localparam int AW  = 11;
    localparam int DW  = COL * BW;

    logic          CLK = 1'b0;
    logic          reset;
    logic          wr_req, wr_acc, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready, rd_ready, rd_valid, busy;
    logic [DW-1:0] rd_data;
    logic          sram_CEN, sram_WEN;
    logic [AW-1:0] sram_A;
    logic [DW-1:0] sram_D, sram_Q;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 CLK = ~CLK;

    psum_bank_ctrl #(.col(COL), .psum_bw(BW), .addr_bw(AW)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_acc   (wr_acc),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .busy     (busy),
        .sram_CEN (sram_CEN),
        .sram_WEN (sram_WEN),
        .sram_A   (sram_A),
        .sram_D   (sram_D),
        .sram_Q   (sram_Q)
    );

    always @(posedge CLK) begin
        if (!sram_CEN) begin
            if (!sram_WEN) mem[sram_A] <= sram_D;
            else           sram_Q <= mem[sram_A];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [BW-1:0] v);
        return {COL{v}};
    endfunction

    function automatic logic [DW-1:0] alt(input logic [BW-1:0] even, input logic [BW-1:0] odd);
        logic [DW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = (i % 2 == 0) ? even : odd;
        return r;
    endfunction

    task automatic idle();
        wr_req = 1'b0;
        wr_acc = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_acc = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        @(negedge CLK); @(negedge CLK); #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_cen", sram_CEN, 1);
        check("rst_wen", sram_WEN, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);

        @(negedge CLK); reset = 1'b0; idle(); #1;
        check("idle_cen", sram_CEN, 1);

        // plain write then read of address 5
        @(negedge CLK); wr_req = 1; wr_acc = 0; wr_addr = 5; wr_data = rep(32'h10); #1;
        check("w5_ready", wr_ready, 1);
        check("w5_cen", sram_CEN, 0);
        check("w5_wen", sram_WEN, 0);
        check("w5_a", sram_A, 5);
        check("w5_d", sram_D, rep(32'h10));
        @(negedge CLK); idle(); rd_req = 1; rd_addr = 5; #1;
        check("r5_ready", rd_ready, 1);
        check("r5_wen", sram_WEN, 1);
        check("r5_a", sram_A, 5);
        check("r5_valid_early", rd_valid, 0);
        @(negedge CLK); idle(); #1;
        check("r5_valid", rd_valid, 1);
        check("r5_data", rd_data, rep(32'h10));

        // accumulate 3 into address 5, read requested during the write-back
        @(negedge CLK); wr_req = 1; wr_acc = 1; wr_addr = 5; wr_data = rep(32'h3); #1;
        check("a5_ready", wr_ready, 1);
        check("a5_rd_wen", sram_WEN, 1);
        check("a5_busy_pre", busy, 0);
        @(negedge CLK); idle(); rd_req = 1; rd_addr = 5; #1;
        check("a5wb_busy", busy, 1);
        check("a5wb_wr_ready", wr_ready, 0);
        check("a5wb_rd_ready", rd_ready, 0);
        check("a5wb_wen", sram_WEN, 0);
        check("a5wb_a", sram_A, 5);
        check("a5wb_d", sram_D, rep(32'h13));
        check("a5wb_no_rd_valid", rd_valid, 0);
        @(negedge CLK); #1;
        check("r5b_ready", rd_ready, 1);
        check("r5b_busy", busy, 0);
        @(negedge CLK); idle(); #1;
        check("r5b_valid", rd_valid, 1);
        check("r5b_data", rd_data, rep(32'h13));

        // wrap: 0xFFFFFFFF + 2 on even lanes, + 0 on odd lanes
        @(negedge CLK); wr_req = 1; wr_acc = 0; wr_addr = 9; wr_data = rep(32'hFFFF_FFFF); #1;
        check("w9_ready", wr_ready, 1);
        @(negedge CLK); wr_acc = 1; wr_data = alt(32'h2, 32'h0); #1;
        check("a9_ready", wr_ready, 1);
        @(negedge CLK); idle(); #1;
        check("a9wb_d", sram_D, alt(32'h1, 32'hFFFF_FFFF));
        @(negedge CLK); rd_req = 1; rd_addr = 9; #1;
        check("r9_ready", rd_ready, 1);
        @(negedge CLK); idle(); #1;
        check("r9_data", rd_data, alt(32'h1, 32'hFFFF_FFFF));

        // contention: both held four cycles, grants alternate W,R,W,R
        @(negedge CLK); wr_req = 1; wr_acc = 0; wr_addr = 20; wr_data = rep(32'hA5); rd_req = 1; rd_addr = 5;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge CLK);
            #1;
            check($sformatf("arb%0d_wr", i), wr_ready, (i % 2 == 0));
            check($sformatf("arb%0d_rd", i), rd_ready, (i % 2 == 1));
            if (i == 2) check("arb2_rd_data", rd_data, rep(32'h13));
        end
        @(negedge CLK); idle(); #1;
        check("arb_last_valid", rd_valid, 1);
        check("arb_last_data", rd_data, rep(32'h13));

        // back-to-back accumulates of 1 into address 7 over 0
        @(negedge CLK); wr_req = 1; wr_acc = 0; wr_addr = 7; wr_data = rep(32'h0); #1;
        check("w7_ready", wr_ready, 1);
        @(negedge CLK); wr_acc = 1; wr_data = rep(32'h1); #1;
        check("a7a_ready", wr_ready, 1);
        @(negedge CLK); #1;
        check("a7a_wb_ready", wr_ready, 0);
        check("a7a_wb_d", sram_D, rep(32'h1));
        @(negedge CLK); #1;
        check("a7b_ready", wr_ready, 1);
        @(negedge CLK); idle(); #1;
        check("a7b_wb_d", sram_D, rep(32'h2));
        @(negedge CLK); rd_req = 1; rd_addr = 7; #1;
        check("r7_ready", rd_ready, 1);
        @(negedge CLK); idle(); #1;
        check("r7_data", rd_data, rep(32'h2));

        // reset during the write-back aborts it
        @(negedge CLK); wr_req = 1; wr_acc = 1; wr_addr = 7; wr_data = rep(32'h1); #1;
        check("a7c_ready", wr_ready, 1);
        @(negedge CLK); idle(); reset = 1; #1;
        check("a7c_rst_wen", sram_WEN, 1);
        check("a7c_rst_busy", busy, 0);
        check("a7c_rst_cen", sram_CEN, 1);
        @(negedge CLK); reset = 0; rd_req = 1; rd_addr = 7; #1;
        check("r7b_ready", rd_ready, 1);
        check("r7b_busy", busy, 0);
        @(negedge CLK); idle(); #1;
        check("r7b_data", rd_data, rep(32'h2));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
